// File: rtl/mod_exp_if.sv
// Request/response bundle for the modular-exponentiation controller, carrying
// both the host-side operation handshake and the multiplier request channel.
interface mod_exp_if #(
    parameter int WIDTH  = 8,
    parameter int EWIDTH = 8
) ();
    logic              start;
    logic [WIDTH-1:0]  base;
    logic [WIDTH-1:0]  mod;
    logic [EWIDTH-1:0] exp;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              error;
    logic              mul_start;
    logic [WIDTH-1:0]  mul_b;
    logic [WIDTH-1:0]  mul_d;
    logic [WIDTH-1:0]  mul_M;
    logic              mul_done;
    logic [WIDTH:0]    mul_z;

    // Environment side: issues operations and hosts the multiplier.
    modport master (
        output start, base, mod, exp, mul_done, mul_z,
        input  busy, done, result, error, mul_start, mul_b, mul_d, mul_M
    );

    // Controller side.
    modport slave (
        input  start, base, mod, exp, mul_done, mul_z,
        output busy, done, result, error, mul_start, mul_b, mul_d, mul_M
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller computing base^exp mod mod,
// delegating each modular product to an external interleaved multiplier.
module mod_exp_ctrl #(
    parameter int WIDTH  = 8,
    parameter int EWIDTH = 8,
    parameter int TMO    = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    mod_exp_if.slave   io_bus
);
    localparam int KW = (EWIDTH > 1) ? $clog2(EWIDTH) : 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        IDLE, REDUCE, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, NEXT, FINISH
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WIDTH-1:0]  r_base;
    logic [WIDTH-1:0]  r_mod;
    logic [EWIDTH-1:0] r_exp;
    logic [KW-1:0]     r_k;
    logic [WIDTH-1:0]  r_acc;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_result;
    logic              r_error;
    logic              w_fin_err;
    logic              w_timeout;
    logic              w_ovf;

    assign w_timeout = (r_cnt >= CW'(TMO - 1));
    assign w_ovf     = io_bus.mul_z[WIDTH];

    always_comb begin
        w_state_next = r_state;
        w_fin_err    = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.start) w_state_next = REDUCE;
            end
            REDUCE: begin
                if (r_mod == '0) begin
                    w_state_next = FINISH;
                    w_fin_err    = 1'b1;
                end else if (r_base < r_mod) begin
                    w_state_next = SQR_REQ;
                end
            end
            SQR_REQ: w_state_next = SQR_WAIT;
            SQR_WAIT: begin
                if (io_bus.mul_done) begin
                    if (w_ovf) begin
                        w_state_next = FINISH;
                        w_fin_err    = 1'b1;
                    end else if (r_exp[r_k]) begin
                        w_state_next = MUL_REQ;
                    end else begin
                        w_state_next = NEXT;
                    end
                end else if (w_timeout) begin
                    w_state_next = FINISH;
                    w_fin_err    = 1'b1;
                end
            end
            MUL_REQ: w_state_next = MUL_WAIT;
            MUL_WAIT: begin
                if (io_bus.mul_done) begin
                    w_state_next = w_ovf ? FINISH : NEXT;
                    w_fin_err    = w_ovf;
                end else if (w_timeout) begin
                    w_state_next = FINISH;
                    w_fin_err    = 1'b1;
                end
            end
            NEXT:    w_state_next = (r_k == '0) ? FINISH : SQR_REQ;
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_mod    <= '0;
            r_exp    <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (io_bus.start) begin
                        r_base  <= io_bus.base;
                        r_mod   <= io_bus.mod;
                        r_exp   <= io_bus.exp;
                        r_k     <= KW'(EWIDTH - 1);
                        r_acc   <= WIDTH'(1);
                        r_error <= 1'b0;
                    end
                end
                REDUCE: begin
                    // Anything mod 1 is 0, so the accumulator starts there.
                    if (r_mod == WIDTH'(1)) r_acc <= '0;
                    if (r_mod != '0 && r_base >= r_mod) r_base <= r_base - r_mod;
                end
                SQR_REQ, MUL_REQ: r_cnt <= CW'(1);
                SQR_WAIT, MUL_WAIT: begin
                    if (io_bus.mul_done) r_acc <= io_bus.mul_z[WIDTH-1:0];
                    else                 r_cnt <= r_cnt + CW'(1);
                end
                NEXT: begin
                    if (r_k != '0) r_k <= r_k - KW'(1);
                end
                default: ;
            endcase
            // Result and error are latched on FINISH entry so they are valid with done.
            if (w_state_next == FINISH && r_state != FINISH) begin
                r_error  <= w_fin_err;
                r_result <= w_fin_err ? '0 : r_acc;
            end
        end
    end

    assign io_bus.busy      = (r_state != IDLE) && (r_state != FINISH);
    assign io_bus.done      = (r_state == FINISH);
    assign io_bus.result    = r_result;
    assign io_bus.error     = r_error;
    assign io_bus.mul_start = (r_state == SQR_REQ) || (r_state == MUL_REQ);
    assign io_bus.mul_b     = r_acc;
    assign io_bus.mul_d     = (r_state == SQR_REQ || r_state == SQR_WAIT) ? r_acc : r_base;
    assign io_bus.mul_M     = r_mod;
endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Directed bench for mod_exp_ctrl with a behavioural 9-cycle modular
// multiplier and a repeated-multiplication reference model.
module tb_mod_exp_ctrl;
    localparam int WIDTH  = 8;
    localparam int EWIDTH = 8;
    localparam int TMO    = 31;
    localparam int LAT    = 9;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    int   pending  = 0;
    int   exp_res  = 0;
    int   exp_err  = 0;
    int   exp_red  = 0;
    int   exp_mod  = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   ms_cnt   = 0;
    int   ms_cyc   = 0;
    bit   withhold   = 1'b0;
    bit   inject_ovf = 1'b0;
    bit   mul_abort  = 1'b0;

    mod_exp_if #(.WIDTH(WIDTH), .EWIDTH(EWIDTH)) bus ();

    mod_exp_ctrl #(.WIDTH(WIDTH), .EWIDTH(EWIDTH), .TMO(TMO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: plain repeated multiplication, independent of bit scanning.
    function automatic int modexp(input int b, input int e, input int m);
        int r;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    // Output monitor: every done and every multiplier request is checked.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (pending == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                check("result", int'(bus.result), exp_res);
                check("error", int'(bus.error), exp_err);
            end
        end
        if (rst_n && bus.mul_start) begin
            ms_cnt++;
            ms_cyc = cyc;
            check("mul_d_operand", int'(bus.mul_d == bus.mul_b || int'(bus.mul_d) == exp_red), 1);
            check("mul_M_operand", int'(bus.mul_M), exp_mod);
        end
    end

    // Behavioural interleaved multiplier: z = b*d mod M, LAT cycles after request.
    initial begin
        int cnt;
        logic [WIDTH-1:0] cb, cd, cm;
        cnt = 0;
        cb = '0; cd = '0; cm = '0;
        bus.mul_done = 1'b0;
        bus.mul_z    = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !withhold) begin
                    if (!mul_abort) begin
                        check("mul_b_stable", int'(bus.mul_b), int'(cb));
                        check("mul_d_stable", int'(bus.mul_d), int'(cd));
                    end
                    bus.mul_z    = 9'((int'(cb) * int'(cd)) % int'(cm)) | (inject_ovf ? 9'h100 : 9'h000);
                    bus.mul_done = 1'b1;
                end
            end else if (rst_n && bus.mul_start) begin
                cb = bus.mul_b; cd = bus.mul_d; cm = bus.mul_M;
                mul_abort = 1'b0;
                cnt = LAT;
            end
        end
    end

    task automatic drive_start(input int b, input int e, input int m);
        @(negedge clk);
        bus.start = 1'b1;
        bus.base  = WIDTH'(b);
        bus.exp   = EWIDTH'(e);
        bus.mod   = WIDTH'(m);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_op(input int b, input int e, input int m, input bit force_err, input bit poke);
        int t_acc;
        int waited;
        if (m == 0 || force_err) begin
            exp_res = 0; exp_err = 1;
        end else begin
            exp_res = modexp(b, e, m); exp_err = 0;
        end
        exp_red  = (m == 0) ? 0 : b % m;
        exp_mod  = m;
        done_cnt = 0;
        ms_cnt   = 0;
        pending  = 1;
        drive_start(b, e, m);
        t_acc = cyc;
        check("busy_after_start", int'(bus.busy), 1);
        waited = 0;
        while (done_cnt == 0 && waited < 2000) begin
            @(negedge clk);
            waited++;
            bus.start = poke && (waited == 5);
            if (poke && waited == 5) begin
                bus.base = 8'd9; bus.exp = 8'd1; bus.mod = 8'd5;
            end
        end
        bus.start = 1'b0;
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        check("done_count", done_cnt, 1);
        check("busy_after_done", int'(bus.busy), 0);
        check("result_held", int'(bus.result), exp_res);
        check("error_held", int'(bus.error), exp_err);
        if (m == 0) begin
            check("mod0_done_latency_ok", int'((done_cyc - t_acc) <= 3), 1);
            check("mod0_no_mul_start", ms_cnt, 0);
        end
        if (withhold) check("timeout_cycles", done_cyc - ms_cyc, TMO);
        $display("op base=%0d exp=%0d mod=%0d -> result=%0d error=%0d (expect %0d/%0d) muls=%0d",
                 b, e, m, bus.result, bus.error, exp_res, exp_err, ms_cnt);
        pending = 0;
    endtask

    initial begin
        int waited;
        bus.start = 1'b0; bus.base = '0; bus.exp = '0; bus.mod = '0;

        check("model_3_5_7", modexp(3, 5, 7), 5);
        check("model_250_3_11", modexp(250, 3, 11), 6);
        check("model_200_0_13", modexp(200, 0, 13), 1);
        check("model_200_0_1", modexp(200, 0, 1), 0);
        check("model_2_10_255", modexp(2, 10, 255), 4);

        repeat (3) @(negedge clk);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_result", int'(bus.result), 0);
        check("rst_error", int'(bus.error), 0);
        check("rst_mul_start", int'(bus.mul_start), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(3, 5, 7, 1'b0, 1'b0);
        run_op(250, 3, 11, 1'b0, 1'b0);
        run_op(200, 0, 13, 1'b0, 1'b0);
        run_op(200, 0, 1, 1'b0, 1'b0);
        run_op(7, 200, 13, 1'b0, 1'b0);
        run_op(255, 255, 251, 1'b0, 1'b0);
        run_op(5, 6, 0, 1'b0, 1'b0);

        withhold = 1'b1;
        run_op(3, 5, 7, 1'b1, 1'b0);
        withhold = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        inject_ovf = 1'b1;
        run_op(3, 5, 7, 1'b1, 1'b0);
        inject_ovf = 1'b0;

        run_op(4, 13, 9, 1'b0, 1'b1);

        // Abort mid-run; the multiplier's late reply must not produce a done.
        exp_red = 3; exp_mod = 7; done_cnt = 0; ms_cnt = 0; pending = 0;
        drive_start(3, 200, 7);
        waited = 0;
        while (ms_cnt < 2 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (ms_cnt < 2) check("abort_setup_timeout", 0, 1);
        repeat (4) @(negedge clk);
        mul_abort = 1'b1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_result", int'(bus.result), 0);
        check("abort_error", int'(bus.error), 0);
        check("abort_mul_start", int'(bus.mul_start), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("no_done_after_abort", done_cnt, 0);
        check("idle_after_abort", int'(bus.busy), 0);

        run_op(3, 5, 7, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
